pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WR registers plus PC).
- Detects load-use hazards.
- Sequences multi-cycle data-memory waits and the multi-cycle mul/div unit (MDU).
- Applies branch and exception flushes.
- Drives the stall/flush inputs of every pipeline register.

Pipeline registers latch on negedge clk. This block updates state on posedge clk, and its stall/flush outputs settle combinationally before the negedge.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_mdu_countdown.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t     : controller FSM states (RUN, MEM_WAIT, MDU_BUSY)
//   REG_ZERO         : architectural zero register index (never a real hazard)
//   DEF_MDU_LAT      : default total MDU cycles per operation
//   DEF_MEM_TIMEOUT  : default data-memory wait limit before a bus error
//   reg_match()      : true when a destination feeds a used source register
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_BUSY = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MDU_LAT     = 32;
    localparam int         DEF_MEM_TIMEOUT = 255;

    // Writes to r0 are discarded, so they can never create a dependency.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] src,
                                       input logic       used);
        return used && (rd == src) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_countdown.sv
// Countdown tracking an in-flight multiply/divide operation.
//   clk       : clock, state updates on rising edge
//   rst_n     : synchronous active-low reset, empties the counter
//   clear     : abort the running operation (flush), wins over load
//   load      : EX stage issues an MDU op this cycle (ignored while busy)
//   busy      : operation in progress (counter != 0)
//   busy_next : value busy will take after the next rising edge
module mdu_countdown
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = DEF_MDU_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    output logic busy,
    output logic busy_next
);

    // The issue cycle itself is one of the MDU_LAT cycles, so the counter
    // only has to cover the remaining MDU_LAT-1.
    localparam int            CNT_W    = $clog2(MDU_LAT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (load && (cnt_reg == '0)) begin
            cnt_next = LOAD_VAL;
        end else if (cnt_reg != '0) begin
            // Keeps counting through memory stalls: the unit runs on its own.
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign busy      = (cnt_reg != '0);
    assign busy_next = (cnt_next != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Pipeline registers latch on negedge; this block updates on posedge and its
// stall/flush outputs are combinational so they settle before the negedge.
// Inputs : ID source regs/usage, MDU use, branch taken, EX load/dest/MDU
//          start, MEM request/ready, MEM exception, rst_n (sync, active low)
// Outputs: stall_* hold enables and flush_* bubble inserts per pipeline
//          register, mdu_busy, bus_err (timeout pulse), stall_cycles counter
// Priority: reset > exception > memory timeout > memory wait >
//           MDU/load-use hazard > taken branch.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT     = DEF_MDU_LAT,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_Id,
    input  logic [4:0]       Rt_Id,
    input  logic             RsUsed_Id,
    input  logic             RtUsed_Id,
    input  logic             UsesMdu_Id,
    input  logic             BranchTaken_Id,
    input  logic             MemRead_Ex,
    input  logic [4:0]       Rd_Ex,
    input  logic             MduStart_Ex,
    input  logic             MemReq_Mem,
    input  logic             MemReady,
    input  logic             Exception_Mem,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             stall_MEM_WR,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WR,
    output logic             mdu_busy,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    // Counter value during the final permitted wait cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state_reg;
    ctrl_state_t       state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [WAIT_W-1:0] wait_cur;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic mem_wait;
    logic mem_timeout;
    logic load_use;
    logic mdu_hazard;
    logic mdu_clear;
    logic mdu_load;
    logic mdu_busy_next;

    // The wait count only means something while already waiting; a fresh
    // wait always starts from zero regardless of any stale register value.
    assign wait_cur    = (state_reg == MEM_WAIT) ? wait_cnt_reg : '0;
    assign mem_wait    = MemReq_Mem && !MemReady;
    assign mem_timeout = mem_wait && (wait_cur == WAIT_LAST);

    assign load_use   = MemRead_Ex && (reg_match(Rd_Ex, Rs_Id, RsUsed_Id) ||
                                       reg_match(Rd_Ex, Rt_Id, RtUsed_Id));
    assign mdu_hazard = mdu_busy && UsesMdu_Id;

    // MEM_WR is never held; a repeated writeback is prevented by a bubble.
    assign stall_MEM_WR = 1'b0;

    always_comb begin
        stall_PC      = 1'b0;
        stall_IF_ID   = 1'b0;
        stall_ID_EX   = 1'b0;
        stall_EX_MEM  = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;
        flush_MEM_WR  = 1'b0;
        bus_err       = 1'b0;
        mdu_clear     = 1'b0;
        wait_cnt_next = '0;
        if (!rst_n) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WR = 1'b1;
            mdu_clear    = 1'b1;
        end else if (Exception_Mem) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WR = 1'b1;
            mdu_clear    = 1'b1;
        end else if (mem_timeout) begin
            // A bus error is handled like an exception: drain everything.
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WR = 1'b1;
            bus_err      = 1'b1;
            mdu_clear    = 1'b1;
        end else if (mem_wait) begin
            stall_PC      = 1'b1;
            stall_IF_ID   = 1'b1;
            stall_ID_EX   = 1'b1;
            stall_EX_MEM  = 1'b1;
            flush_MEM_WR  = 1'b1;
            wait_cnt_next = wait_cur + WAIT_W'(1);
        end else if (mdu_hazard || load_use) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else begin
            // Only reached when IF_ID is not held; a held branch re-resolves.
            flush_IF_ID = BranchTaken_Id;
        end
    end

    // An MDU op issues only when its EX instruction actually advances.
    assign mdu_load = MduStart_Ex && !stall_ID_EX;

    mdu_countdown #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_countdown (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (mdu_clear),
        .load      (mdu_load),
        .busy      (mdu_busy),
        .busy_next (mdu_busy_next)
    );

    // State shows the highest-priority condition active for the next cycle.
    always_comb begin
        state_next = RUN;
        if (!Exception_Mem && mem_wait && !mem_timeout) begin
            state_next = MEM_WAIT;
        end else if (mdu_busy_next) begin
            state_next = MDU_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (stall_PC) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MDU_LAT=4, MEM_TIMEOUT=4,
// CNT_W=4 so the stall counter wraps during the run). Each scenario task
// drives one cycle at a time, pushes the expected outputs/state/counter to a
// scoreboard queue, and pops and compares at the following negedge.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TB_MDU_LAT     = 4;
    localparam int TB_MEM_TIMEOUT = 4;
    localparam int TB_CNT_W       = 4;

    // Output vector: {stall PC,IF_ID,ID_EX,EX_MEM,MEM_WR}_{flush IF_ID,ID_EX,
    // EX_MEM,MEM_WR}_{mdu_busy}_{bus_err}
    localparam logic [10:0] V_IDLE  = 11'b00000_0000_0_0;
    localparam logic [10:0] V_HAZ   = 11'b11000_0100_0_0;
    localparam logic [10:0] V_BR    = 11'b00000_1000_0_0;
    localparam logic [10:0] V_MEMW  = 11'b11110_0001_0_0;
    localparam logic [10:0] V_FLUSH = 11'b00000_1111_0_0;
    localparam logic [10:0] V_TMO   = 11'b00000_1111_0_1;
    localparam logic [10:0] V_BUSY  = 11'b00000_0000_1_0;

    typedef struct packed {
        logic       rst_n;
        logic       exc;
        logic       memreq;
        logic       memready;
        logic       mdu_start;
        logic       memread;
        logic [4:0] rd;
        logic       uses_mdu;
        logic       br;
        logic [4:0] rs;
        logic       rs_used;
        logic [4:0] rt;
        logic       rt_used;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [10:0] ev;
        ctrl_state_t es;
    } cyc_t;

    typedef struct {
        string                name;
        int                   idx;
        logic [10:0]          ev;
        ctrl_state_t          es;
        logic [TB_CNT_W-1:0]  ec;
    } exp_t;

    localparam stim_t IDLE = '{rst_n: 1'b1, default: '0};

    logic clk;
    logic rst_n;
    logic [4:0] Rs_Id, Rt_Id, Rd_Ex;
    logic RsUsed_Id, RtUsed_Id, UsesMdu_Id, BranchTaken_Id;
    logic MemRead_Ex, MduStart_Ex, MemReq_Mem, MemReady, Exception_Mem;
    logic stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WR;
    logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WR;
    logic mdu_busy, bus_err;
    logic [TB_CNT_W-1:0] stall_cycles;

    exp_t                sb_q[$];
    logic [TB_CNT_W-1:0] exp_cnt;
    int                  n_cmp;
    int                  n_bad;

    pipe_hazard_ctrl #(
        .MDU_LAT     (TB_MDU_LAT),
        .MEM_TIMEOUT (TB_MEM_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Rs_Id          (Rs_Id),
        .Rt_Id          (Rt_Id),
        .RsUsed_Id      (RsUsed_Id),
        .RtUsed_Id      (RtUsed_Id),
        .UsesMdu_Id     (UsesMdu_Id),
        .BranchTaken_Id (BranchTaken_Id),
        .MemRead_Ex     (MemRead_Ex),
        .Rd_Ex          (Rd_Ex),
        .MduStart_Ex    (MduStart_Ex),
        .MemReq_Mem     (MemReq_Mem),
        .MemReady       (MemReady),
        .Exception_Mem  (Exception_Mem),
        .stall_PC       (stall_PC),
        .stall_IF_ID    (stall_IF_ID),
        .stall_ID_EX    (stall_ID_EX),
        .stall_EX_MEM   (stall_EX_MEM),
        .stall_MEM_WR   (stall_MEM_WR),
        .flush_IF_ID    (flush_IF_ID),
        .flush_ID_EX    (flush_ID_EX),
        .flush_EX_MEM   (flush_EX_MEM),
        .flush_MEM_WR   (flush_MEM_WR),
        .mdu_busy       (mdu_busy),
        .bus_err        (bus_err),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input stim_t s);
        rst_n          = s.rst_n;
        Exception_Mem  = s.exc;
        MemReq_Mem     = s.memreq;
        MemReady       = s.memready;
        MduStart_Ex    = s.mdu_start;
        MemRead_Ex     = s.memread;
        Rd_Ex          = s.rd;
        UsesMdu_Id     = s.uses_mdu;
        BranchTaken_Id = s.br;
        Rs_Id          = s.rs;
        RsUsed_Id      = s.rs_used;
        Rt_Id          = s.rt;
        RtUsed_Id      = s.rt_used;
    endtask

    function automatic logic [10:0] obs_vec();
        return {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WR,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WR,
                mdu_busy, bus_err};
    endfunction

    // Push expectation for a cycle and advance the stall-counter model.
    task automatic push_exp(input string nm, input int idx, input cyc_t c);
        exp_t e;
        e.name = nm;
        e.idx  = idx;
        e.ev   = c.ev;
        e.es   = c.es;
        e.ec   = exp_cnt;
        sb_q.push_back(e);
        if (!c.s.rst_n)     exp_cnt = '0;
        else if (c.ev[10])  exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        cyc_t tab[2] = '{
            '{'{default: '0}, V_FLUSH, RUN},
            '{IDLE,           V_IDLE,  RUN}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("reset", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("reset[%0d] outputs=%b stall_cycles=%0d", i, o, stall_cycles);
        end
    endtask

    task automatic test_load_use();
        cyc_t tab[9] = '{
            '{'{rst_n: 1'b1, memread: 1'b1, rd: 5'd5, rs: 5'd5, rs_used: 1'b1, default: '0}, V_HAZ, RUN},
            '{IDLE, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memread: 1'b1, rd: 5'd7, rt: 5'd7, rt_used: 1'b1, default: '0}, V_HAZ, RUN},
            '{'{rst_n: 1'b1, memread: 1'b1, rd: 5'd7, rs: 5'd7, rt: 5'd7, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memread: 1'b1, rd: 5'd0, rs: 5'd0, rs_used: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, rd: 5'd5, rs: 5'd5, rs_used: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memread: 1'b1, rd: 5'd9, rs: 5'd9, rs_used: 1'b1, br: 1'b1, default: '0}, V_HAZ, RUN},
            '{'{rst_n: 1'b1, br: 1'b1, default: '0}, V_BR, RUN},
            '{IDLE, V_IDLE, RUN}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("load_use", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 2;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            $display("load_use[%0d] outputs=%b stall_cycles=%0d", i, o, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        cyc_t tab[6] = '{
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, br: 1'b1, default: '0}, V_MEMW, MEM_WAIT},
            '{'{rst_n: 1'b1, memreq: 1'b1, memread: 1'b1, rd: 5'd5, rs: 5'd5, rs_used: 1'b1, default: '0}, V_MEMW, MEM_WAIT},
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_IDLE, MEM_WAIT},
            '{IDLE, V_IDLE, RUN}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("mem_wait", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("mem_wait[%0d] outputs=%b state=%0d", i, o, dut.state_reg);
        end
    endtask

    task automatic test_timeout();
        cyc_t tab[7] = '{
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, MEM_WAIT},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, MEM_WAIT},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_TMO,  MEM_WAIT},
            '{IDLE, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_IDLE, MEM_WAIT}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("timeout", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("timeout[%0d] outputs=%b state=%0d", i, o, dut.state_reg);
        end
    endtask

    task automatic test_mdu();
        cyc_t tab[12] = '{
            '{'{rst_n: 1'b1, mdu_start: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_HAZ | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_HAZ | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, br: 1'b1, default: '0}, V_HAZ | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, mdu_start: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_IDLE, MEM_WAIT},
            '{'{rst_n: 1'b1, mdu_start: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_BUSY, MEM_WAIT},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_HAZ | V_BUSY, MDU_BUSY},
            '{IDLE, V_IDLE, RUN}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("mdu", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("mdu[%0d] outputs=%b state=%0d", i, o, dut.state_reg);
        end
    endtask

    task automatic test_exception();
        cyc_t tab[6] = '{
            '{'{rst_n: 1'b1, mdu_start: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, exc: 1'b1, memreq: 1'b1, uses_mdu: 1'b1, br: 1'b1, memread: 1'b1,
                rd: 5'd5, rs: 5'd5, rs_used: 1'b1, default: '0}, V_FLUSH | V_BUSY, MEM_WAIT},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, exc: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_FLUSH, RUN},
            '{IDLE, V_IDLE, RUN}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("exception", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("exception[%0d] outputs=%b state=%0d", i, o, dut.state_reg);
        end
    endtask

    // Back-to-back load-use hazards; also pushes the 4-bit counter past wrap.
    task automatic test_back_to_back();
        cyc_t c;
        exp_t e;
        logic [10:0] o;
        for (int i = 0; i < 13; i++) begin
            c.s  = IDLE;
            c.ev = V_IDLE;
            c.es = RUN;
            if (i < 12) begin
                c.s.memread = 1'b1;
                c.s.rd      = 5'(i + 1);
                if (i % 2 == 0) begin
                    c.s.rs = 5'(i + 1); c.s.rs_used = 1'b1;
                end else begin
                    c.s.rt = 5'(i + 1); c.s.rt_used = 1'b1;
                end
                c.ev = V_HAZ;
            end
            @(posedge clk); #1;
            apply(c.s);
            push_exp("back_to_back", i, c);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 2;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            $display("back_to_back[%0d] outputs=%b stall_cycles=%0d", i, o, stall_cycles);
        end
    endtask

    task automatic test_reset_mid_wait();
        cyc_t tab[7] = '{
            '{'{rst_n: 1'b1, mdu_start: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW | V_BUSY, MDU_BUSY},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW | V_BUSY, MEM_WAIT},
            '{'{memreq: 1'b1, uses_mdu: 1'b1, default: '0}, V_FLUSH | V_BUSY, MEM_WAIT},
            '{'{rst_n: 1'b1, uses_mdu: 1'b1, default: '0}, V_IDLE, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, default: '0}, V_MEMW, RUN},
            '{'{rst_n: 1'b1, memreq: 1'b1, memready: 1'b1, default: '0}, V_IDLE, MEM_WAIT}
        };
        exp_t e;
        logic [10:0] o;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            apply(tab[i].s);
            push_exp("reset_mid_wait", i, tab[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = obs_vec();
            n_cmp += 3;
            if (o !== e.ev) begin
                n_bad++; $display("FAIL %s[%0d] outputs got %b required %b", e.name, e.idx, o, e.ev);
            end
            if (stall_cycles !== e.ec) begin
                n_bad++; $display("FAIL %s[%0d] stall_cycles got %0d required %0d", e.name, e.idx, stall_cycles, e.ec);
            end
            if (dut.state_reg !== e.es) begin
                n_bad++; $display("FAIL %s[%0d] state got %0d required %0d", e.name, e.idx, dut.state_reg, e.es);
            end
            $display("reset_mid_wait[%0d] outputs=%b state=%0d stall_cycles=%0d", i, o, dut.state_reg, stall_cycles);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = '0;
        apply('{default: '0});
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_mdu();
        test_exception();
        test_back_to_back();
        test_reset_mid_wait();
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain leftover %0d required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
